inst_fetch_arbiter: RTL and testbench
=====================================

# inst_fetch_arbiter

Shares one single-ported instruction-memory interface between the processor's two fetch ports (Inst1, Inst2). It grants requests round-robin, tracks up to MAX_OUT in-flight fetches in an ordered tag queue, and steers each in-order memory response back to the port that issued it. A pipeline flush discards all in-flight responses. The block sits between the fetch stage of `Processor` and the instruction memory model or bus.

## Interface
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction word width
- MAX_OUT, 4, maximum outstanding memory requests; power of two, ≥2
- SystemClock  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill all in-flight fetches; block new grants this cycle
- inst1_req_valid / inst2_req_valid  in  1  fetch request from port 1 / 2
- inst1_req_addr / inst2_req_addr  in  ADDR_W  fetch address
- inst1_req_ready / inst2_req_ready  out  1  request accepted this cycle
- inst1_resp_valid / inst2_resp_valid  out  1  one-cycle response strobe
- inst1_resp_data / inst2_resp_data  out  DATA_W  fetched instruction
- mem_req_valid  out  1  request to memory
- mem_req_addr  out  ADDR_W  address of the granted port
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  memory response; responses return strictly in request order
- mem_resp_data  in  DATA_W  response word
- err  out  1  sticky protocol-error flag

## Operation
- `full` = (count == MAX_OUT), evaluated on the pre-update count. A same-cycle pop does not free a slot for a same-cycle grant.
- Grant selection:
  - Only one port requesting: grant it.
  - Both requesting: grant the port holding priority.
  - Priority resets to port 1. After each completed transfer it moves to the non-granted port.
- `mem_req_valid` = (inst1_req_valid | inst2_req_valid) & !full & !flush & !rst.
- `mem_req_addr` = the granted port's address; 0 when no port is granted.
- `instN_req_ready` = grantN & mem_req_valid & mem_req_ready. Ready is never asserted to the non-granted port.
- Requesters hold valid and addr stable until ready. Priority does not move while the memory stalls.
- On transfer, push tag {owner, kill=0} into the queue.
- On each `mem_resp_valid`, pop the queue head:
  - kill=0: register the data to the owner port; assert its resp_valid for exactly one cycle.
  - kill=1: drop the response silently.
- `flush`: set kill on every queue entry, including a head popped in the same cycle, so that response is dropped too. No grant that cycle. The count is unaffected; killed entries drain as their responses return.
- `mem_resp_valid` with an empty queue: ignore the response, set `err` (sticky until rst).
- Push and pop in the same cycle: count unchanged.
- `rst` overrides everything. Mid-operation reset clears the queue, count, priority and err. Responses for pre-reset requests arriving afterwards are therefore unexpected and set err. The integration is responsible for resetting the memory alongside this block.
- Reset values: all resp_valid = 0, resp_data = 0, err = 0, count = 0, priority = port 1. `mem_req_valid` and ready outputs are 0 during rst.

## Timing
- Request path is combinational: request to mem_req in the same cycle; ready in the same cycle as mem_req_ready.
- Response latency: mem_resp_valid in cycle T gives instN_resp_valid in cycle T+1.
- Throughput: one grant per cycle and one response per cycle, concurrently.
- With memory latency L, the steady-state fetch rate is one per cycle if MAX_OUT ≥ L+1.
- Flush in cycle T: the first grant is possible in T+1.

## Structure
- System_Pkg holds:
  - fetch_req_t {valid, addr}
  - fetch_resp_t {valid, data}
  - fetch_tag_t {owner (0 = Inst1, 1 = Inst2), kill}
  - FETCH_MAX_OUT default constant
- Sub-module `fetch_tag_fifo`: MAX_OUT-deep circular buffer of fetch_tag_t.
  - Pointers are log2(MAX_OUT)+1 bits; the MSB distinguishes full from empty on wrap.
  - Provides a broadcast kill-all input.
- The arbiter owns priority, grant logic, the response register and err.

## Test plan
- Reset then idle: all outputs 0.
  - inst1 only, addr 0x100, mem_req_ready=1, mem_resp 0xAAAA_0001 two cycles later -> inst1_req_ready same cycle; inst1_resp_valid one cycle after mem_resp with data 0xAAAA_0001; inst2 silent.
- Both ports valid continuously (0x200 / 0x300), memory always ready, 1-cycle response -> grants alternate 1,2,1,2. Responses are routed to the matching port in order.
- Memory latency 10, MAX_OUT=4 -> exactly 4 grants, then mem_req_valid stays 0 until the first response pops. Case: pop and a waiting request in the same cycle -> grant occurs the next cycle.
- Three fetches in flight, flush pulsed while the first response arrives -> no instN_resp_valid for any of the three. A new request in the cycle after flush is granted and its response delivered.
- mem_resp_valid with an empty queue -> err=1 and held; no resp_valid; rst clears err. Case: rst mid-stream with 2 in flight -> outputs return to reset values next cycle.
- mem_req_ready held 0 for 5 cycles with both ports valid -> granted port and address stable; priority unchanged; neither ready asserted.

Source files
------------

// File: rtl/inst_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : inst_fetch_arbiter_pkg
// Purpose : Shared types and constants for the instruction-fetch arbiter:
//           request/response bundles, the in-flight fetch tag and the
//           default outstanding-request depth.
// Ports   : n/a (package)
// Rev     : 1.0  initial release
// ============================================================================
package inst_fetch_arbiter_pkg;

  localparam int FETCH_MAX_OUT = 4;
  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_DATA_W  = 32;

  // Which fetch port issued a request.
  typedef enum logic {
    OWNER_INST1 = 1'b0,
    OWNER_INST2 = 1'b1
  } fetch_owner_e;

  typedef struct packed {
    logic                    valid;
    logic [FETCH_ADDR_W-1:0] addr;
  } fetch_req_t;

  typedef struct packed {
    logic                    valid;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_resp_t;

  // One entry per in-flight fetch; kill marks a response to be discarded.
  typedef struct packed {
    fetch_owner_e owner;
    logic         kill;
  } fetch_tag_t;

endpackage : inst_fetch_arbiter_pkg
`default_nettype wire

// File: rtl/inst_fetch_arbiter_fetch_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_tag_fifo
// Purpose : DEPTH-deep circular buffer of in-flight fetch tags, kept in
//           memory-request order, with a broadcast kill-all.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           push, push_tag  - append a tag (ignored when full)
//           pop             - drop the head tag (ignored when empty)
//           kill_all        - set kill on every stored entry
//           head_tag        - current oldest entry
//           empty, full     - occupancy flags
// Rev     : 1.0  initial release
// ============================================================================
module fetch_tag_fifo
  import inst_fetch_arbiter_pkg::*;
#(
  parameter int DEPTH = FETCH_MAX_OUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_tag_t push_tag,
  input  logic       pop,
  input  logic       kill_all,
  output fetch_tag_t head_tag,
  output logic       empty,
  output logic       full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so equal indices can be told apart
  // as either empty (same wrap) or full (opposite wrap).
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  fetch_tag_t [DEPTH-1:0] slot_q, slot_d;

  logic w_do_push;
  logic w_do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign head_tag = slot_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(w_do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(w_do_pop);
    // Marking free slots too is harmless: a push overwrites the whole entry.
    if (kill_all) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_d[i].kill = 1'b1;
      end
    end
    if (w_do_push) begin
      slot_d[wr_ptr_q[IDX_W-1:0]] = push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      slot_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      slot_q   <= slot_d;
    end
  end

endmodule : fetch_tag_fifo
`default_nettype wire

// File: rtl/inst_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_arbiter
// Purpose : Shares one instruction-memory port between two fetch ports with
//           round-robin grants, up to MAX_OUT in-flight fetches, in-order
//           response steering and pipeline-flush kill of in-flight fetches.
// Ports   : SystemClock, rst            - clock, sync active-high reset
//           flush                       - kill in-flight fetches, no grant
//           instN_req_valid/addr/ready  - fetch request handshake, N = 1,2
//           instN_resp_valid/data       - registered one-cycle response
//           mem_req_valid/addr/ready    - memory request handshake
//           mem_resp_valid/data         - in-order memory response
//           err                         - sticky unexpected-response flag
// Rev     : 1.0  initial release
// ============================================================================
module inst_fetch_arbiter
  import inst_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = FETCH_MAX_OUT
) (
  input  logic              SystemClock,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst1_req_valid,
  input  logic [ADDR_W-1:0] inst1_req_addr,
  output logic              inst1_req_ready,
  input  logic              inst2_req_valid,
  input  logic [ADDR_W-1:0] inst2_req_addr,
  output logic              inst2_req_ready,
  output logic              inst1_resp_valid,
  output logic [DATA_W-1:0] inst1_resp_data,
  output logic              inst2_resp_valid,
  output logic [DATA_W-1:0] inst2_resp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              err
);

  fetch_owner_e      prio_q, prio_d;
  logic              err_q, err_d;
  logic              resp1_valid_q, resp1_valid_d;
  logic              resp2_valid_q, resp2_valid_d;
  logic [DATA_W-1:0] resp1_data_q, resp1_data_d;
  logic [DATA_W-1:0] resp2_data_q, resp2_data_d;

  logic       w_grant1, w_grant2;
  logic       w_xfer;
  logic       w_pop;
  logic       w_deliver;
  logic       w_empty, w_full;
  fetch_tag_t w_head;
  fetch_tag_t w_push_tag;

  // Port 2 wins only when alone or when it holds priority.
  assign w_grant2 = inst2_req_valid & (~inst1_req_valid | (prio_q == OWNER_INST2));
  assign w_grant1 = inst1_req_valid & ~w_grant2;

  // full is the pre-update occupancy, so a same-cycle pop never frees a slot.
  assign mem_req_valid = (inst1_req_valid | inst2_req_valid) & ~w_full & ~flush & ~rst;
  assign mem_req_addr  = w_grant1 ? inst1_req_addr :
                         w_grant2 ? inst2_req_addr : '0;

  assign w_xfer          = mem_req_valid & mem_req_ready;
  assign inst1_req_ready = w_grant1 & w_xfer;
  assign inst2_req_ready = w_grant2 & w_xfer;

  assign w_push_tag.owner = w_grant2 ? OWNER_INST2 : OWNER_INST1;
  assign w_push_tag.kill  = 1'b0;

  // A flush in the pop cycle kills that head as well, hence the extra term.
  assign w_pop     = mem_resp_valid & ~w_empty;
  assign w_deliver = w_pop & ~w_head.kill & ~flush;

  fetch_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk      (SystemClock),
    .rst      (rst),
    .push     (w_xfer),
    .push_tag (w_push_tag),
    .pop      (w_pop),
    .kill_all (flush),
    .head_tag (w_head),
    .empty    (w_empty),
    .full     (w_full)
  );

  always_comb begin
    prio_d        = prio_q;
    err_d         = err_q | (mem_resp_valid & w_empty);
    resp1_valid_d = 1'b0;
    resp2_valid_d = 1'b0;
    resp1_data_d  = resp1_data_q;
    resp2_data_d  = resp2_data_q;
    // Priority moves only on a completed transfer, so stalls keep it put.
    if (w_xfer) begin
      prio_d = w_grant1 ? OWNER_INST2 : OWNER_INST1;
    end
    if (w_deliver) begin
      if (w_head.owner == OWNER_INST2) begin
        resp2_valid_d = 1'b1;
        resp2_data_d  = mem_resp_data;
      end else begin
        resp1_valid_d = 1'b1;
        resp1_data_d  = mem_resp_data;
      end
    end
  end

  always_ff @(posedge SystemClock) begin
    if (rst) begin
      prio_q        <= OWNER_INST1;
      err_q         <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp2_valid_q <= 1'b0;
      resp1_data_q  <= '0;
      resp2_data_q  <= '0;
    end else begin
      prio_q        <= prio_d;
      err_q         <= err_d;
      resp1_valid_q <= resp1_valid_d;
      resp2_valid_q <= resp2_valid_d;
      resp1_data_q  <= resp1_data_d;
      resp2_data_q  <= resp2_data_d;
    end
  end

  assign inst1_resp_valid = resp1_valid_q;
  assign inst2_resp_valid = resp2_valid_q;
  assign inst1_resp_data  = resp1_data_q;
  assign inst2_resp_data  = resp2_data_q;
  assign err              = err_q;

endmodule : inst_fetch_arbiter
`default_nettype wire

// File: tb/tb_inst_fetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch_arbiter
// Purpose : Self-checking bench for inst_fetch_arbiter. A queue-based model
//           of outstanding fetches, a round-robin priority variable and a
//           latency-queue memory predict every output each cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_inst_fetch_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              v1, v2;
  logic [ADDR_W-1:0] a1, a2;
  logic              rdy1, rdy2;
  logic              rv1, rv2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              mreq_v;
  logic [ADDR_W-1:0] mreq_a;
  logic              mreq_rdy;
  logic              mresp_v;
  logic [DATA_W-1:0] mresp_d;
  logic              err;

  always #5 clk = ~clk;

  inst_fetch_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .SystemClock      (clk),
    .rst              (rst),
    .flush            (flush),
    .inst1_req_valid  (v1),
    .inst1_req_addr   (a1),
    .inst1_req_ready  (rdy1),
    .inst2_req_valid  (v2),
    .inst2_req_addr   (a2),
    .inst2_req_ready  (rdy2),
    .inst1_resp_valid (rv1),
    .inst1_resp_data  (rd1),
    .inst2_resp_valid (rv2),
    .inst2_resp_data  (rd2),
    .mem_req_valid    (mreq_v),
    .mem_req_addr     (mreq_a),
    .mem_req_ready    (mreq_rdy),
    .mem_resp_valid   (mresp_v),
    .mem_resp_data    (mresp_d),
    .err              (err)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    bit owner;   // 0 = port 1, 1 = port 2
    bit kill;
  } tag_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } mem_t;

  tag_t        mq[$];        // outstanding fetches in request order
  mem_t        memq[$];      // memory pipeline
  int          prio;         // port holding priority (1 or 2)
  bit          m_err;
  bit          m_rv1, m_rv2;
  logic [31:0] m_rd1, m_rd2;
  bit          m_after_rst;
  bit          acc1, acc2;

  int          cyc;
  int          mem_lat;
  int          req_mode;     // 0 one-shot, 1 hold valid, 2 random
  int          rdy_mode;     // 0 never, 1 always, 2 random
  bit          flush_on_resp;
  int          resp_seq;

  int          n_pass;
  int          n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One full clock: check at negedge, advance model, step to next cycle.
  task automatic cycle();
    bit   full, g1, g2, mv, xfer;
    tag_t t;
    mem_t m;
    @(negedge clk);
    full = (mq.size() == MAX_OUT);
    g2   = v2 && (!v1 || prio == 2);
    g1   = v1 && !g2;
    mv   = (v1 || v2) && !full && !flush && !rst;
    xfer = mv && mreq_rdy;

    chk("mem_req_valid", 32'(mreq_v), 32'(mv));
    if (mv) chk("mem_req_addr", mreq_a, g1 ? a1 : a2);
    chk("inst1_req_ready", 32'(rdy1), 32'(g1 && xfer));
    chk("inst2_req_ready", 32'(rdy2), 32'(g2 && xfer));
    chk("inst1_resp_valid", 32'(rv1), 32'(m_rv1));
    chk("inst2_resp_valid", 32'(rv2), 32'(m_rv2));
    if (m_rv1 || m_after_rst) chk("inst1_resp_data", rd1, m_after_rst ? 32'h0 : m_rd1);
    if (m_rv2 || m_after_rst) chk("inst2_resp_data", rd2, m_after_rst ? 32'h0 : m_rd2);
    chk("err", 32'(err), 32'(m_err));

    acc1 = g1 && xfer;
    acc2 = g2 && xfer;
    m_rv1 = 0;
    m_rv2 = 0;
    if (rst) begin
      mq.delete();
      memq.delete();
      prio        = 1;
      m_err       = 0;
      m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      if (mresp_v) begin
        if (mq.size() == 0) begin
          m_err = 1;
        end else begin
          t = mq.pop_front();
          if (!t.kill && !flush) begin
            if (t.owner) begin m_rv2 = 1; m_rd2 = mresp_d; end
            else         begin m_rv1 = 1; m_rd1 = mresp_d; end
          end
        end
      end
      if (flush) for (int i = 0; i < mq.size(); i++) mq[i].kill = 1;
      if (xfer) begin
        t.owner = g2;
        t.kill  = 0;
        mq.push_back(t);
        prio = g1 ? 2 : 1;
        m.due  = cyc + mem_lat;
        m.data = 32'hAAAA_0000 + 32'(resp_seq);
        resp_seq++;
        memq.push_back(m);
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    flush = 0;
    case (req_mode)
      0: begin
        if (acc1) v1 = 0;
        if (acc2) v2 = 0;
      end
      2: begin
        if (!v1 || acc1) begin v1 = 1'($urandom_range(0, 1)); a1 = $urandom & ~32'h3; end
        if (!v2 || acc2) begin v2 = 1'($urandom_range(0, 1)); a2 = $urandom & ~32'h3; end
        flush = ($urandom_range(0, 19) == 0);
      end
      default: ;
    endcase
    case (rdy_mode)
      0:       mreq_rdy = 0;
      1:       mreq_rdy = 1;
      default: mreq_rdy = ($urandom_range(0, 3) != 0);
    endcase
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m       = memq.pop_front();
      mresp_v = 1;
      mresp_d = m.data;
      if (flush_on_resp) begin flush = 1; flush_on_resp = 0; end
    end else begin
      mresp_v = 0;
      mresp_d = $urandom;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; resp_seq = 1;
    rst = 1; flush = 0; v1 = 0; v2 = 0; a1 = '0; a2 = '0;
    mreq_rdy = 1; mresp_v = 0; mresp_d = '0;
    req_mode = 0; rdy_mode = 1; mem_lat = 1; flush_on_resp = 0;
    prio = 1; m_err = 0; m_rv1 = 0; m_rv2 = 0; m_rd1 = '0; m_rd2 = '0;
    m_after_rst = 0; acc1 = 0; acc2 = 0;

    // Reset, then idle.
    repeat (2) cycle();
    rst = 0;
    repeat (2) cycle();

    // Single fetch on port 1, response two cycles later.
    mem_lat = 2; v1 = 1; a1 = 32'h100;
    repeat (5) cycle();

    // Both ports continuously valid: grants alternate.
    req_mode = 1; mem_lat = 1;
    v1 = 1; a1 = 32'h200; v2 = 1; a2 = 32'h300;
    repeat (8) cycle();
    req_mode = 0; v1 = 0; v2 = 0;
    repeat (3) cycle();

    // Latency 10: queue fills at MAX_OUT, refills after each pop.
    req_mode = 1; mem_lat = 10; v1 = 1; a1 = 32'h400;
    repeat (16) cycle();
    req_mode = 0; v1 = 0;
    repeat (12) cycle();

    // Three in flight, flush coincides with the first response.
    mem_lat = 4;
    v1 = 1; a1 = 32'h500; cycle();
    v2 = 1; a2 = 32'h600; cycle();
    v1 = 1; a1 = 32'h700; cycle();
    flush_on_resp = 1;
    repeat (2) cycle();
    v2 = 1; a2 = 32'h800;
    repeat (8) cycle();

    // Response with nothing outstanding sets sticky err; reset clears it.
    begin
      mem_t m;
      m.due = cyc + 1; m.data = 32'hDEAD_BEEF;
      memq.push_back(m);
    end
    repeat (4) cycle();
    rst = 1; cycle();
    rst = 0; cycle();

    // Reset with two fetches in flight.
    mem_lat = 6;
    v1 = 1; a1 = 32'h900; cycle();
    v2 = 1; a2 = 32'hA00; cycle();
    rst = 1; cycle();
    rst = 0;
    repeat (8) cycle();

    // Memory stalls five cycles with both ports valid.
    req_mode = 1; rdy_mode = 0; mem_lat = 1;
    v1 = 1; a1 = 32'hB00; v2 = 1; a2 = 32'hC00;
    mreq_rdy = 0;
    repeat (5) cycle();
    rdy_mode = 1; mreq_rdy = 1;
    repeat (4) cycle();
    req_mode = 0; v1 = 0; v2 = 0;
    repeat (4) cycle();

    // Randomized traffic, flushes and backpressure at several latencies.
    req_mode = 2; rdy_mode = 2;
    for (int k = 0; k < 8; k++) begin
      mem_lat = $urandom_range(1, 7);
      repeat (150) cycle();
    end
    req_mode = 0; rdy_mode = 1; v1 = 0; v2 = 0;
    repeat (20) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_inst_fetch_arbiter
`default_nettype wire
